sd_bd_queue: RTL

Buffer-descriptor queue for the SD controller data path; one instance serves the TX direction and one the RX direction. Software pushes 2-word descriptors (system address, then card block argument) through a host write port. The data master fetches the head descriptor word-by-word through a request/acknowledge read port, and retires it with a completion strobe. The block also reports the free-slot count that the data master compares against its empty value.

---
 rtl/sd_bd_if.sv | 25 ++
 rtl/sd_bd_queue.sv | 127 ++++++++++++
 2 files changed

// File: rtl/sd_bd_if.sv
// Host-write / master-read bundle of the SD buffer-descriptor queue.
// The slave side is the queue; the master side is the host plus the data master.
interface sd_bd_if #(
    parameter int unsigned BD_WIDTH = 4
);
    logic                we_m;
    logic [31:0]         dat_in_m;
    logic                new_bw;
    logic                wr_err;
    logic [BD_WIDTH-1:0] free_bd;
    logic                re_s;
    logic                ack_o_s;
    logic [31:0]         dat_out_s;
    logic                a_cmp;

    modport slave (
        input  we_m, dat_in_m, re_s, a_cmp,
        output new_bw, wr_err, free_bd, ack_o_s, dat_out_s
    );

    modport master (
        output we_m, dat_in_m, re_s, a_cmp,
        input  new_bw, wr_err, free_bd, ack_o_s, dat_out_s
    );
endinterface

// File: rtl/sd_bd_queue.sv
// Buffer-descriptor queue: host pushes 2-word descriptors, the data master
// fetches the head word-by-word and retires it with a completion strobe.
module sd_bd_queue #(
    parameter int unsigned PTR_W    = 3,
    parameter int unsigned BD_DEPTH = 2**PTR_W,
    parameter int unsigned BD_WIDTH = PTR_W + 1
) (
    input  logic        clk,
    input  logic        rst,
    sd_bd_if.slave      bus
);
    localparam int unsigned ADDR_W = PTR_W + 1;
    localparam int unsigned WORDS  = 2 * BD_DEPTH;
    localparam logic [BD_WIDTH-1:0] FREE_ALL = BD_WIDTH'(BD_DEPTH);
    localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(BD_DEPTH - 1);

    typedef enum logic [2:0] {
        RD_IDLE = 3'd0,
        RD_W0   = 3'd1,
        RD_GAP  = 3'd2,
        RD_W1   = 3'd3,
        RD_DONE = 3'd4
    } rd_state_e;

    rd_state_e           rd_state_q, rd_state_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic                wr_half_q, wr_half_d;
    logic [BD_WIDTH-1:0] free_bd_q, free_bd_d;
    logic                new_bw_q, new_bw_d;
    logic                wr_err_q, wr_err_d;
    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic [31:0]         mem_q [WORDS];

    logic                has_bd;
    logic                wr_accept;
    logic                commit;
    logic                retire;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [ADDR_W-1:0]   mem_raddr;

    // Write side: word storage, commit/retire bookkeeping and pointer wrap.
    always_comb begin
        has_bd    = (free_bd_q != FREE_ALL);
        wr_accept = bus.we_m && (free_bd_q != '0);
        commit    = wr_accept && wr_half_q;
        retire    = bus.a_cmp && has_bd;
        mem_waddr = {wr_ptr_q, wr_half_q};

        wr_half_d = wr_half_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        free_bd_d = free_bd_q;
        new_bw_d  = commit;
        wr_err_d  = bus.we_m && (free_bd_q == '0);

        if (wr_accept) wr_half_d = ~wr_half_q;
        if (commit)    wr_ptr_d  = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        if (retire)    rd_ptr_d  = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);

        case ({commit, retire})
            2'b10:   free_bd_d = free_bd_q - BD_WIDTH'(1);
            2'b01:   free_bd_d = free_bd_q + BD_WIDTH'(1);
            default: free_bd_d = free_bd_q;
        endcase
    end

    // Read FSM; ack and data are registered off the next state so the ack
    // lands in the cycle right after re_s is sampled.
    always_comb begin
        rd_state_d = rd_state_q;
        ack_d      = 1'b0;
        dat_d      = dat_q;

        case (rd_state_q)
            RD_IDLE: if (bus.re_s && has_bd) rd_state_d = RD_W0;
            RD_W0:   rd_state_d = RD_GAP;
            RD_GAP:  rd_state_d = RD_W1;
            RD_W1:   rd_state_d = RD_DONE;
            RD_DONE: rd_state_d = RD_DONE;
            default: rd_state_d = RD_IDLE;
        endcase
        if (!bus.re_s) rd_state_d = RD_IDLE;

        mem_raddr = {rd_ptr_q, (rd_state_d == RD_W1)};
        if ((rd_state_d == RD_W0) || (rd_state_d == RD_W1)) begin
            ack_d = 1'b1;
            dat_d = mem_q[mem_raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_state_q <= RD_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            wr_half_q  <= 1'b0;
            free_bd_q  <= FREE_ALL;
            new_bw_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_half_q  <= wr_half_d;
            free_bd_q  <= free_bd_d;
            new_bw_q   <= new_bw_d;
            wr_err_q   <= wr_err_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
        end
    end

    // Descriptor storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst && wr_accept) mem_q[mem_waddr] <= bus.dat_in_m;
    end

    assign bus.new_bw    = new_bw_q;
    assign bus.wr_err    = wr_err_q;
    assign bus.free_bd   = free_bd_q;
    assign bus.ack_o_s   = ack_q;
    assign bus.dat_out_s = dat_q;
endmodule
